// File: rtl/piso_arb_ctrl.sv
// Round-robin front end for an external PISO: picks one of two requesters, loads its word, frames the serial bits.
// Define PISO_ARB_PARITY_EN to append one even-parity bit after each word.
module piso_arb_ctrl #(
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              piso_load,
  output logic [DATA_W-1:0] piso_din,
  input  logic              piso_dout,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_src,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Handshake: reqN/dataN are sampled only in IDLE; ackN pulses for the single LOAD
  // cycle of the frame that captured wordN. A req still high afterwards is a new word.

  localparam int CNT_MAX    = (DATA_W > GAP_CYCLES) ? DATA_W : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
`ifdef PISO_ARB_PARITY_EN
    PAR   = 3'd3,
`endif
    GAP   = 3'd4
  } state_t;

  state_t             state_q, state_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic               last_q;
  logic               any_req;
  logic               win1;

  assign any_req = req0 | req1;
  // On a tie the requester not served last wins; a lone request wins outright.
  assign win1    = req1 & (~req0 | ~last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      piso_din <= '0;
      ser_src  <= 1'b0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      if (state_q == IDLE && any_req) begin
        piso_din <= win1 ? data1 : data0;
        ser_src  <= win1;
        last_q   <= win1;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_next = '0;
        if (any_req) state_next = LOAD;
      end
      LOAD: begin
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_next = '0;
`ifdef PISO_ARB_PARITY_EN
          state_next = PAR;
`else
          state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
`endif
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end
`ifdef PISO_ARB_PARITY_EN
      PAR: begin
        cnt_next   = '0;
        state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
`endif
      GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST_I)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    piso_load = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    case (state_q)
      LOAD: begin
        piso_load = 1'b1;
        ack0      = ~ser_src;
        ack1      = ser_src;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = piso_dout;
      end
`ifdef PISO_ARB_PARITY_EN
      PAR: begin
        ser_valid = 1'b1;
        ser_out   = ^piso_din;
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Bench for piso_arb_ctrl: main instance (GAP_CYCLES=1) and a GAP_CYCLES=0 instance, each with a PISO model.
module tb_piso_arb_ctrl;

  localparam int DW = 4;
`ifdef PISO_ARB_PARITY_EN
  localparam int FRAME_BITS = DW + 1;
`else
  localparam int FRAME_BITS = DW;
`endif
  localparam int PERIOD  = 2 + FRAME_BITS + 1;
  localparam int PERIOD0 = 2 + FRAME_BITS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance
  logic          req0, req1, ack0, ack1, piso_load, piso_dout;
  logic [DW-1:0] data0, data1, piso_din;
  logic          ser_out, ser_valid, ser_src, busy;
  logic [2:0]    state_dbg;

  // zero-gap instance
  logic          g_req0, g_req1, g_ack0, g_ack1, g_piso_load, g_piso_dout;
  logic [DW-1:0] g_data0, g_data1, g_piso_din;
  logic          g_ser_out, g_ser_valid, g_ser_src, g_busy;
  logic [2:0]    g_state_dbg;

  piso_arb_ctrl #(.DATA_W(DW), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .piso_load(piso_load), .piso_din(piso_din), .piso_dout(piso_dout),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_src(ser_src),
    .busy(busy), .state_dbg(state_dbg)
  );

  piso_arb_ctrl #(.DATA_W(DW), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset(reset),
    .req0(g_req0), .data0(g_data0), .ack0(g_ack0),
    .req1(g_req1), .data1(g_data1), .ack1(g_ack1),
    .piso_load(g_piso_load), .piso_din(g_piso_din), .piso_dout(g_piso_dout),
    .ser_out(g_ser_out), .ser_valid(g_ser_valid), .ser_src(g_ser_src),
    .busy(g_busy), .state_dbg(g_state_dbg)
  );

  // PISO models: load on piso_load, MSB first, one bit per cycle.
  logic [DW-1:0] sreg = '0, g_sreg = '0;
  always @(posedge clk) begin
    if (piso_load) sreg <= piso_din;
    else           sreg <= {sreg[DW-2:0], 1'b0};
    if (g_piso_load) g_sreg <= g_piso_din;
    else             g_sreg <= {g_sreg[DW-2:0], 1'b0};
  end
  assign piso_dout   = sreg[DW-1];
  assign g_piso_dout = g_sreg[DW-1];

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];
  logic       mon_e;

  // Serial stream scoreboard for the main instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (ser_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ser_bit: unexpected bit %0b, none expected", ser_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (ser_out !== mon_e) begin
            n_err++;
            $display("FAIL ser_bit: got %0b want %0b", ser_out, mon_e);
          end
        end
      end else begin
        n_cmp++;
        if (ser_out !== 1'b0) begin
          n_err++;
          $display("FAIL ser_out_idle: got %0b want 0", ser_out);
        end
      end
    end
  end

  task automatic push_frame(input logic [DW-1:0] w);
    for (int b = DW - 1; b >= 0; b--) exp_q.push_back(w[b]);
`ifdef PISO_ARB_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL %s_idle: busy still 1 want 0", name); end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d bits left want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, piso_load, ser_out, ser_valid, ser_src, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outs: got %b want 0000000",
               {ack0, ack1, piso_load, ser_out, ser_valid, ser_src, busy});
    end
    n_cmp++;
    if (piso_din !== '0) begin n_err++; $display("FAIL reset_din: got %b want 0000", piso_din); end
    n_cmp++;
    if (state_dbg !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_cmp++;
    if ({g_busy, g_piso_load, g_ser_valid, g_state_dbg} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_g0: got %b want 000000", {g_busy, g_piso_load, g_ser_valid, g_state_dbg});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single();
    int at = -1;
    req0 = 1'b1; data0 = 4'b1001;
    push_frame(4'b1001);
    for (int i = 0; i < 6 && at < 0; i++) begin
      @(negedge clk);
      if (ack0) at = i;
    end
    n_cmp++;
    if (at != 1) begin n_err++; $display("FAIL single_latency: ack at %0d want 1", at); end
    n_cmp++;
    if ({piso_load, ack1, ser_src, piso_din} !== {3'b100, 4'b1001}) begin
      n_err++;
      $display("FAIL single_load: got %b want 1001001", {piso_load, ack1, ser_src, piso_din});
    end
    @(posedge clk); #1 req0 = 1'b0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      @(negedge clk);
      n_cmp++;
      if ({ser_valid, ack0, piso_load} !== 3'b100) begin
        n_err++;
        $display("FAIL single_shift%0d: got %b want 100", b, {ser_valid, ack0, piso_load});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({ser_valid, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL single_gap: valid/busy got %b want 01", {ser_valid, busy});
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL single_done: busy got %b want 0", busy); end
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    logic [1:0]    pat [3];
    logic [DW-1:0] words [3];
    int cyc = 0, n_ack = 0, t_prev = 0;
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01;
    words[0] = 4'b1010; words[1] = 4'b1111; words[2] = 4'b1010;
    pulse_reset();
    req0 = 1'b1; data0 = 4'b1010;
    req1 = 1'b1; data1 = 4'b1111;
    for (int k = 0; k < 3; k++) push_frame(words[k]);
    while (n_ack < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        n_cmp++;
        if ({ack1, ack0} !== pat[n_ack]) begin
          n_err++;
          $display("FAIL b2b_ack%0d: got %b want %b", n_ack, {ack1, ack0}, pat[n_ack]);
        end
        n_cmp++;
        if ({ser_src, piso_din} !== {pat[n_ack][1], words[n_ack]}) begin
          n_err++;
          $display("FAIL b2b_src%0d: got %b want %b", n_ack, {ser_src, piso_din},
                   {pat[n_ack][1], words[n_ack]});
        end
        if (n_ack > 0) begin
          n_cmp++;
          if (cyc - t_prev != PERIOD) begin
            n_err++;
            $display("FAIL b2b_period%0d: got %0d want %0d", n_ack, cyc - t_prev, PERIOD);
          end
        end
        t_prev = cyc;
        n_ack++;
      end
    end
    n_cmp++;
    if (n_ack != 3) begin n_err++; $display("FAIL b2b_timeout: acks %0d want 3", n_ack); end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    req0 = 1'b1; data0 = 4'b0110;
    req1 = 1'b1; data1 = 4'b0011;
    push_frame(4'b0011);
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (ack0 || ack1) seen = 1;
    end
    n_cmp++;
    if ({seen, ack1, ack0} !== 3'b110) begin
      n_err++;
      $display("FAIL mid_first: seen/ack1/ack0 got %b want 110", {seen, ack1, ack0});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({ser_valid, busy, ack0, ack1} !== 4'b0) begin
      n_err++;
      $display("FAIL mid_abort: valid/busy/ack0/ack1 got %b want 0000", {ser_valid, busy, ack0, ack1});
    end
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    push_frame(4'b0110);
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (ack0 || ack1) seen = 1;
    end
    n_cmp++;
    if ({seen, ack0, ack1, ser_src, piso_din} !== {3'b110, 1'b0, 4'b0110}) begin
      n_err++;
      $display("FAIL mid_after: got %b want 11000110", {seen, ack0, ack1, ser_src, piso_din});
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    wait_idle("mid");
  endtask

  task automatic test_drop();
    bit seen = 0;
    req0 = 1'b1; data0 = 4'b1100;
    push_frame(4'b1100);
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (ack0) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL drop_ack0: got 0 want 1"); end
    @(posedge clk); #1 req0 = 1'b0;
    @(posedge clk); #1 req1 = 1'b1; data1 = 4'b0101;
    @(posedge clk); #1 req1 = 1'b0;
    for (int i = 0; i < PERIOD + 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ack1, piso_load} !== 2'b00) begin
        n_err++;
        $display("FAIL drop_noack%0d: ack1/load got %b want 00", i, {ack1, piso_load});
      end
    end
    wait_idle("drop");
  endtask

  task automatic test_gap0();
    int cyc = 0, n_load = 0, t_prev = 0;
    g_req0 = 1'b1; g_data0 = 4'b1011;
    while (n_load < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (g_piso_load) begin
        if (n_load > 0) begin
          n_cmp++;
          if (cyc - t_prev != PERIOD0) begin
            n_err++;
            $display("FAIL gap0_period%0d: got %0d want %0d", n_load, cyc - t_prev, PERIOD0);
          end
        end
        n_cmp++;
        if ({g_ack0, g_ack1, g_ser_src, g_piso_din} !== {3'b100, 4'b1011}) begin
          n_err++;
          $display("FAIL gap0_load%0d: got %b want 1001011", n_load,
                   {g_ack0, g_ack1, g_ser_src, g_piso_din});
        end
        t_prev = cyc;
        n_load++;
      end
      n_cmp++;
      if (!g_ser_valid && g_busy && !g_piso_load) begin
        n_err++;
        $display("FAIL gap0_hole: ser_valid 0 in state %0d want IDLE/LOAD", g_state_dbg);
      end
      n_cmp++;
      if (!g_ser_valid && g_ser_out !== 1'b0) begin
        n_err++;
        $display("FAIL gap0_out: ser_out got %b want 0", g_ser_out);
      end
    end
    n_cmp++;
    if (n_load != 3) begin n_err++; $display("FAIL gap0_timeout: loads %0d want 3", n_load); end
    @(posedge clk); #1 g_req0 = 1'b0;
    repeat (PERIOD0 + 2) @(negedge clk);
    n_cmp++;
    if (g_busy !== 1'b0) begin n_err++; $display("FAIL gap0_idle: busy got %b want 0", g_busy); end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    g_req0 = 1'b0; g_req1 = 1'b0; g_data0 = '0; g_data1 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_gap0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_arb_ctrl.md
PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4: PISO parallel word width.
REQ-002 SHALL have parameter GAP_CYCLES, default 1: idle cycles after each frame, 0 allowed.
REQ-003 SHALL have port clk, input, 1: rising-edge clock, the only clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req0, input, 1: requester 0 has a word pending.
REQ-006 SHALL have port data0, input, DATA_W: requester 0 word, stable while req0=1.
REQ-007 SHALL have port ack0, output, 1: one-cycle pulse, word0 captured.
REQ-008 SHALL have port req1, input, 1: requester 1 has a word pending.
REQ-009 SHALL have port data1, input, DATA_W: requester 1 word, stable while req1=1.
REQ-010 SHALL have port ack1, output, 1: one-cycle pulse, word1 captured.
REQ-011 SHALL have port piso_load, output, 1: load strobe to the PISO.
REQ-012 SHALL have port piso_din, output, DATA_W: registered parallel word to the PISO.
REQ-013 SHALL have port piso_dout, input, 1: serial bit returned from the PISO.
REQ-014 SHALL have port ser_out, output, 1: framed serial line.
REQ-015 SHALL have port ser_valid, output, 1: ser_out carries a frame bit.
REQ-016 SHALL have port ser_src, output, 1: index of the requester owning the current frame.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, LOAD, SHIFT, PAR (macro only), GAP.
REQ-019 In IDLE with any req high, SHALL move to LOAD, register winner's data into piso_din, set ser_src and last-served pointer.
REQ-020 Arbitration SHALL be round-robin: on tie, winner is the requester not last served; single request wins outright.
REQ-021 ackN SHALL be high for exactly the LOAD cycle of a frame won by requester N.
REQ-022 piso_load SHALL be high for exactly the LOAD cycle; PISO contract: first frame bit on piso_dout in the cycle after LOAD, one new bit per cycle.
REQ-023 SHIFT SHALL last DATA_W cycles, counted by a bit counter 0..DATA_W-1; ser_out=piso_dout, ser_valid=1.
REQ-024 After SHIFT: PAR if macro defined, else GAP if GAP_CYCLES>0, else IDLE.
REQ-025 GAP SHALL last GAP_CYCLES cycles with ser_valid=0, then IDLE.
REQ-026 ser_out SHALL be 0 whenever ser_valid=0.
REQ-027 Requests SHALL be sampled only in IDLE; a req dropped before IDLE produces no ack and no frame.
REQ-028 A req held high after its ack SHALL be treated as a new word at the next IDLE.
REQ-029 Latency: req sampled in IDLE at edge k -> ack in cycle k+1 -> first ser_valid in cycle k+2.
REQ-030 Frame period, back-to-back: 2 + DATA_W + parity bit (0/1) + GAP_CYCLES cycles.

Reset
REQ-031 Reset SHALL force state IDLE, bit counter 0, last-served pointer 1 (requester 0 wins first tie).
REQ-032 Reset SHALL drive ack0, ack1, piso_load, piso_din, ser_out, ser_valid, ser_src, busy to 0.
REQ-033 Reset mid-frame SHALL abort the frame on the next cycle; the aborted word is discarded and not re-sent.

Configuration
REQ-034 Macro PISO_ARB_PARITY_EN defined: after SHIFT, one PAR cycle with ser_valid=1, ser_out=XOR of piso_din (even parity); frame is DATA_W+1 bits.
REQ-035 Macro undefined: no PAR state and no parity logic; frame is DATA_W bits.

Verification (DATA_W=4, GAP_CYCLES=1, bench PISO model attached)
REQ-036 Reset held 2 cycles -> all outputs 0, busy=0.
REQ-037 Single req0, data0=4'b1001 -> ack0 and piso_load high 1 cycle with piso_din=1001; ser_valid 4 cycles (5 with parity, parity bit 0) matching piso_dout; 1 gap cycle; busy low after.
REQ-038 req0 (1010) and req1 (1111) both held -> acks alternate ack0, ack1, ack0; ser_src matches; period 7 cycles (8 with parity).
REQ-039 Reset in 3rd SHIFT cycle with req0 and req1 held -> next cycle ser_valid=0, busy=0; after release, req0 is served first.
REQ-040 req1 high for 1 cycle while busy, low before IDLE -> no ack1, no frame from requester 1.
REQ-041 GAP_CYCLES=0, req0 held -> LOAD cycles 6 cycles apart (7 with parity), no ser_valid=0 cycle other than IDLE/LOAD.
